// File: rtl/axi_stream_pkg.sv
// Shared types and helpers for the AXI-Stream slave-side monitor.
//   popcount : number of set bits in a vector of up to pop_max_w bits
//   sat_add  : add two values and clamp the result to all-ones of a given width
package axi_stream_pkg;

  localparam int unsigned pop_max_w = 256;
  localparam int unsigned sat_max_w = 64;
  localparam int unsigned sat_sum_w = sat_max_w + 1;

  // One flag per master-side handshake rule seen in the current cycle.
  typedef struct packed {
    logic vld_drop;     // tvalid withdrawn while a beat was stalled
    logic payload_chg;  // payload altered while a beat was stalled
    logic strb_keep;    // tstrb asserted on a byte tkeep marks as null
    logic early_vld;    // tvalid already high in the first cycle after reset
  } proto_viol_t;

  // Count set bits; callers zero-extend their vector to pop_max_w.
  function automatic int unsigned popcount(input logic [pop_max_w-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < pop_max_w; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  // Saturating add: the result is clamped to (2**width - 1); width <= sat_max_w.
  function automatic logic [sat_max_w-1:0] sat_add(input logic [sat_max_w-1:0] a,
                                                   input logic [sat_max_w-1:0] b,
                                                   input int unsigned width);
    logic [sat_max_w:0] sum;
    logic [sat_max_w:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (sat_sum_w'(1) << width) - sat_sum_w'(1);
    if (sum > lim) begin
      sum = lim;
    end
    return sat_max_w'(sum);
  endfunction

endpackage

// File: rtl/axi_stream_sat_counter.sv
// Saturating event counter with asynchronous clear.
//   clk, resetn : clock and async active-low clear
//   en          : add inc on this edge
//   inc         : increment amount
//   count       : registered running total, sticks at all-ones
module axi_stream_sat_counter
  import axi_stream_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Next total, clamped at all-ones of WIDTH.
  always_comb begin
    w_next = WIDTH'(sat_add(sat_max_w'(r_count), sat_max_w'(inc), WIDTH));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_next;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/axi_stream_slave_monitor.sv
// Passive AXI-Stream monitor at the sink side of a link.
//   Inputs : clk, resetn (async active-low), tvalid, tready, tdata, tstrb,
//            tkeep, tlast, tid, tdest, tuser (all observed, never driven)
//   Outputs: transfer_count, byte_count, packet_count - saturating statistics
//            in_packet      - a packet has started but not yet seen tlast
//            stall_cycles   - length of the current tvalid && !tready run
//            err_protocol   - sticky, master handshake rule broken
//            err_stall      - sticky, slave stalled for max_stall cycles
module axi_stream_slave_monitor
  import axi_stream_pkg::*;
#(
  parameter int unsigned byte_width  = 4,
  parameter int unsigned id_width    = 0,
  parameter int unsigned dest_width  = 0,
  parameter int unsigned user_width  = 0,
  parameter int unsigned count_width = 32,
  parameter int unsigned max_stall   = 16
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      tvalid,
  input  logic                                      tready,
  input  logic [8*byte_width-1:0]                   tdata,
  input  logic [byte_width-1:0]                     tstrb,
  input  logic [byte_width-1:0]                     tkeep,
  input  logic                                      tlast,
  input  logic [((id_width > 0) ? id_width : 1)-1:0]     tid,
  input  logic [((dest_width > 0) ? dest_width : 1)-1:0] tdest,
  input  logic [((user_width > 0) ? user_width : 1)-1:0] tuser,
  output logic [count_width-1:0]                    transfer_count,
  output logic [count_width-1:0]                    byte_count,
  output logic [count_width-1:0]                    packet_count,
  output logic                                      in_packet,
  output logic [count_width-1:0]                    stall_cycles,
  output logic                                      err_protocol,
  output logic                                      err_stall
);

  localparam int unsigned data_w = 8 * byte_width;
  localparam int unsigned id_w   = (id_width > 0) ? id_width : 1;
  localparam int unsigned dest_w = (dest_width > 0) ? dest_width : 1;
  localparam int unsigned user_w = (user_width > 0) ? user_width : 1;
  localparam int unsigned pay_w  = data_w + 2 * byte_width + 1 + id_w + dest_w + user_w;
  localparam int unsigned pop_w  = $clog2(byte_width + 1);

  localparam logic id_en   = (id_width != 0);
  localparam logic dest_en = (dest_width != 0);
  localparam logic user_en = (user_width != 0);

  // Absent sideband fields are kept in the payload word but never compared.
  localparam logic [pay_w-1:0] pay_mask = {{(data_w + 2 * byte_width + 1){1'b1}},
                                           {id_w{id_en}}, {dest_w{dest_en}},
                                           {user_w{user_en}}};

  // With the check disabled the stall run only stops at all-ones.
  localparam logic [count_width-1:0] stall_cap =
    (max_stall == 0) ? {count_width{1'b1}} : count_width'(max_stall);

  logic                   w_xfer;
  logic                   w_stall;
  logic [pay_w-1:0]       w_payload;
  proto_viol_t            w_viol;
  logic                   w_viol_any;
  logic [count_width-1:0] w_stall_next;
  logic                   w_stall_hit;
  logic [pop_w-1:0]       w_keep_pop;

  logic                   r_armed;        // low only in the first cycle after release
  logic                   r_stalled;      // previous cycle had tvalid && !tready
  logic [pay_w-1:0]       r_prev_payload;
  logic [count_width-1:0] r_stall_cycles;
  logic                   r_in_packet;
  logic                   r_err_protocol;
  logic                   r_err_stall;

  // Handshake classification, rule checks and stall-run arithmetic.
  always_comb begin
    w_xfer     = tvalid && tready;
    w_stall    = tvalid && !tready;
    w_payload  = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
    w_keep_pop = pop_w'(popcount(pop_max_w'(tkeep)));

    // r_stalled is cleared by reset, so the stalled-beat rules stay quiet
    // in the first cycle after release.
    w_viol             = '0;
    w_viol.vld_drop    = r_stalled && !tvalid;
    w_viol.payload_chg = r_stalled && (|((w_payload ^ r_prev_payload) & pay_mask));
    w_viol.strb_keep   = tvalid && (|(tstrb & ~tkeep));
    w_viol.early_vld   = tvalid && !r_armed;
    w_viol_any         = |w_viol;

    w_stall_next = '0;
    if (w_stall) begin
      w_stall_next = (r_stall_cycles == stall_cap) ? stall_cap
                                                   : r_stall_cycles + count_width'(1);
    end
    w_stall_hit = (max_stall != 0) && w_stall && (w_stall_next == stall_cap);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_armed        <= 1'b0;
      r_stalled      <= 1'b0;
      r_prev_payload <= '0;
      r_stall_cycles <= '0;
      r_in_packet    <= 1'b0;
      r_err_protocol <= 1'b0;
      r_err_stall    <= 1'b0;
    end else begin
      r_armed        <= 1'b1;
      r_stalled      <= w_stall;
      r_prev_payload <= w_payload;
      r_stall_cycles <= w_stall_next;
      if (w_xfer) begin
        r_in_packet <= !tlast;
      end
      r_err_protocol <= r_err_protocol | w_viol_any;
      r_err_stall    <= r_err_stall | w_stall_hit;
    end
  end

  axi_stream_sat_counter #(
    .WIDTH     (count_width),
    .INC_WIDTH (1)
  ) u_transfer_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (w_xfer),
    .inc    (1'b1),
    .count  (transfer_count)
  );

  axi_stream_sat_counter #(
    .WIDTH     (count_width),
    .INC_WIDTH (pop_w)
  ) u_byte_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (w_xfer),
    .inc    (w_keep_pop),
    .count  (byte_count)
  );

  axi_stream_sat_counter #(
    .WIDTH     (count_width),
    .INC_WIDTH (1)
  ) u_packet_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (w_xfer && tlast),
    .inc    (1'b1),
    .count  (packet_count)
  );

  assign in_packet    = r_in_packet;
  assign stall_cycles = r_stall_cycles;
  assign err_protocol = r_err_protocol;
  assign err_stall    = r_err_stall;

`ifdef FORMAL
  // Set after the opening beat of a packet until the next transfer.
  logic r_pair_open;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pair_open <= 1'b0;
    end else if (w_xfer) begin
      r_pair_open <= !tlast && !r_in_packet;
    end
  end

  // Master rules constrain the inputs; the stall bound is the slave's duty.
  always @(posedge clk) begin
    if (resetn) begin
      assume (!w_viol.vld_drop);
      assume (!w_viol.payload_chg);
      assume (!w_viol.strb_keep);
      assume (!w_viol.early_vld);
      assert (!w_stall_hit);
      cover (w_xfer && tlast && r_pair_open);
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_slave_monitor.sv
// Directed bench for axi_stream_slave_monitor: two instances share the
// stimulus (A: 32-bit counters, stall bound 4; B: 4-bit counters, bound off)
// and are compared every cycle against a rule-level model, with literal
// expectations at key points.
module tb_axi_stream_slave_monitor;

  logic        clk;
  logic        resetn;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic [3:0]  tkeep;
  logic        tlast;
  logic [0:0]  tid;
  logic [0:0]  tdest;
  logic [0:0]  tuser;

  logic [31:0] tc_a, bc_a, pc_a, st_a;
  logic        inp_a, ep_a, es_a;
  logic [3:0]  tc_b, bc_b, pc_b, st_b;
  logic        inp_b, ep_b, es_b;

  int n_vec;
  int n_fail;

  axi_stream_slave_monitor #(
    .byte_width (4), .id_width (0), .dest_width (0), .user_width (0),
    .count_width (32), .max_stall (4)
  ) u_dut_a (
    .clk (clk), .resetn (resetn), .tvalid (tvalid), .tready (tready),
    .tdata (tdata), .tstrb (tstrb), .tkeep (tkeep), .tlast (tlast),
    .tid (tid), .tdest (tdest), .tuser (tuser),
    .transfer_count (tc_a), .byte_count (bc_a), .packet_count (pc_a),
    .in_packet (inp_a), .stall_cycles (st_a),
    .err_protocol (ep_a), .err_stall (es_a)
  );

  axi_stream_slave_monitor #(
    .byte_width (4), .id_width (0), .dest_width (0), .user_width (0),
    .count_width (4), .max_stall (0)
  ) u_dut_b (
    .clk (clk), .resetn (resetn), .tvalid (tvalid), .tready (tready),
    .tdata (tdata), .tstrb (tstrb), .tkeep (tkeep), .tlast (tlast),
    .tid (tid), .tdest (tdest), .tuser (tuser),
    .transfer_count (tc_b), .byte_count (bc_b), .packet_count (pc_b),
    .in_packet (inp_b), .stall_cycles (st_b),
    .err_protocol (ep_b), .err_stall (es_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model (index 0 = A, 1 = B) ----------------
  longint     m_tc [2];
  longint     m_bc [2];
  longint     m_pc [2];
  longint     m_st [2];
  bit         m_es [2];
  bit         m_inp;
  bit         m_ep;
  bit         m_fresh;
  bit         m_prev_stall;
  logic [40:0] m_prev_pay;

  function automatic longint cnt_cap(input int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd15;
  endfunction

  function automatic longint bound(input int k);
    return (k == 0) ? 64'd4 : 64'd0;
  endfunction

  function automatic longint min2(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_tc[k] = 0; m_bc[k] = 0; m_pc[k] = 0; m_st[k] = 0; m_es[k] = 0;
    end
    m_inp = 0; m_ep = 0; m_fresh = 1; m_prev_stall = 0; m_prev_pay = '0;
  endtask

  // Apply the rules to the values about to be sampled on the next edge.
  task automatic model_edge();
    logic [40:0] pay;
    bit xfer, stl;
    longint lim;
    pay  = {tdata, tstrb, tkeep, tlast};
    xfer = tvalid && tready;
    stl  = tvalid && !tready;
    if (m_fresh && tvalid) m_ep = 1;
    if (!m_fresh && m_prev_stall && (!tvalid || pay != m_prev_pay)) m_ep = 1;
    if (tvalid && ((tstrb & ~tkeep) != 4'h0)) m_ep = 1;
    for (int k = 0; k < 2; k++) begin
      if (xfer) begin
        m_tc[k] = min2(m_tc[k] + 1, cnt_cap(k));
        m_bc[k] = min2(m_bc[k] + $countones(tkeep), cnt_cap(k));
        if (tlast) m_pc[k] = min2(m_pc[k] + 1, cnt_cap(k));
      end
      lim = (bound(k) != 0) ? bound(k) : cnt_cap(k);
      m_st[k] = stl ? min2(m_st[k] + 1, lim) : 0;
      if (bound(k) != 0 && stl && m_st[k] == bound(k)) m_es[k] = 1;
    end
    if (xfer) m_inp = !tlast;
    m_prev_stall = stl;
    m_prev_pay   = pay;
    m_fresh      = 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("tc_a", longint'(tc_a), m_tc[0]);
    chk("bc_a", longint'(bc_a), m_bc[0]);
    chk("pc_a", longint'(pc_a), m_pc[0]);
    chk("st_a", longint'(st_a), m_st[0]);
    chk("inp_a", longint'(inp_a), longint'(m_inp));
    chk("ep_a", longint'(ep_a), longint'(m_ep));
    chk("es_a", longint'(es_a), longint'(m_es[0]));
    chk("tc_b", longint'(tc_b), m_tc[1]);
    chk("bc_b", longint'(bc_b), m_bc[1]);
    chk("pc_b", longint'(pc_b), m_pc[1]);
    chk("st_b", longint'(st_b), m_st[1]);
    chk("inp_b", longint'(inp_b), longint'(m_inp));
    chk("ep_b", longint'(ep_b), longint'(m_ep));
    chk("es_b", longint'(es_b), longint'(m_es[1]));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    if (!resetn) model_reset();
    else model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_in(input bit v, input bit r, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] k, input bit l);
    tvalid = v; tready = r; tdata = d; tstrb = s; tkeep = k; tlast = l;
  endtask

  // Pulse reset from a falling edge; outputs must clear without a clock.
  task automatic do_reset();
    set_in(0, 0, 32'h0, 4'h0, 4'h0, 0);
    resetn = 1'b0;
    model_reset();
    #1;
    compare_all();
    step();
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    resetn = 1'b0;
    tid = 1'b0; tdest = 1'b0; tuser = 1'b0;
    set_in(0, 0, 32'h0, 4'h0, 4'h0, 0);
    model_reset();
    steps(2);
    chk("lit_rst_tc_a", longint'(tc_a), 0);
    chk("lit_rst_ep_a", longint'(ep_a), 0);

    // Release with tvalid low: no early-valid error.
    resetn = 1'b1;
    step();
    chk("lit_rel_ep_a", longint'(ep_a), 0);

    // Three full beats, the last closing the packet.
    set_in(1, 1, 32'h1111_1111, 4'hF, 4'hF, 0); step();
    set_in(1, 1, 32'h2222_2222, 4'hF, 4'hF, 0); step();
    set_in(1, 1, 32'h3333_3333, 4'hF, 4'hF, 1); step();
    chk("lit_tc3_a", longint'(tc_a), 3);
    chk("lit_bc12_a", longint'(bc_a), 12);
    chk("lit_pc1_a", longint'(pc_a), 1);
    chk("lit_inp0_a", longint'(inp_a), 0);
    chk("lit_ep0_a", longint'(ep_a), 0);

    // Partial beats: 2 bytes then 1 byte.
    set_in(1, 1, 32'h4444_4444, 4'h3, 4'h3, 0); step();
    chk("lit_inp1_a", longint'(inp_a), 1);
    chk("lit_bc14_a", longint'(bc_a), 14);
    set_in(1, 1, 32'h5555_5555, 4'h1, 4'h1, 1); step();
    chk("lit_inp0b_a", longint'(inp_a), 0);
    chk("lit_bc15_a", longint'(bc_a), 15);
    chk("lit_pc2_a", longint'(pc_a), 2);

    // B's 4-bit byte counter sticks at 15.
    set_in(1, 1, 32'h6666_6666, 4'hF, 4'hF, 1); step();
    chk("lit_bc19_a", longint'(bc_a), 19);
    chk("lit_bcsat_b", longint'(bc_b), 15);
    chk("lit_tc6_b", longint'(tc_b), 6);

    // Three stall cycles (tid toggles but is absent), then accepted.
    set_in(1, 0, 32'h7777_7777, 4'hF, 4'hF, 0); step();
    tid = 1'b1; step();
    tid = 1'b0; step();
    chk("lit_st3_a", longint'(st_a), 3);
    chk("lit_es0_a", longint'(es_a), 0);
    tready = 1'b1; step();
    chk("lit_st0_a", longint'(st_a), 0);
    chk("lit_es0b_a", longint'(es_a), 0);
    chk("lit_ep0b_a", longint'(ep_a), 0);
    set_in(0, 0, 32'h0, 4'h0, 4'h0, 0); step();

    // Long stall: A flags at 4 and caps; B runs on to 15.
    set_in(1, 0, 32'h8888_8888, 4'hF, 4'hF, 1); steps(4);
    chk("lit_st4_a", longint'(st_a), 4);
    chk("lit_es1_a", longint'(es_a), 1);
    chk("lit_st4_b", longint'(st_b), 4);
    steps(2);
    chk("lit_stcap_a", longint'(st_a), 4);
    steps(11);
    chk("lit_stcap_b", longint'(st_b), 15);
    chk("lit_es0_b", longint'(es_b), 0);
    tready = 1'b1; step();
    chk("lit_tc8_a", longint'(tc_a), 8);
    chk("lit_pc4_a", longint'(pc_a), 4);
    chk("lit_st0_b", longint'(st_b), 0);
    chk("lit_es_keep_a", longint'(es_a), 1);

    // Payload change during a stall, then sticky through clean traffic.
    do_reset();
    resetn = 1'b1; step();
    set_in(1, 0, 32'hA5A5_A5A5, 4'hF, 4'hF, 0); step();
    chk("lit_ep_pre_a", longint'(ep_a), 0);
    tdata = 32'h0; step();
    chk("lit_ep_chg_a", longint'(ep_a), 1);
    set_in(1, 1, 32'h1, 4'hF, 4'hF, 0); step();
    tdata = 32'h2; step();
    tdata = 32'h3; step();
    chk("lit_ep_sticky_a", longint'(ep_a), 1);
    chk("lit_tc3b_a", longint'(tc_a), 3);
    chk("lit_inp1b_a", longint'(inp_a), 1);
    set_in(1, 0, 32'h4, 4'hF, 4'hF, 0); steps(2);
    chk("lit_st2_a", longint'(st_a), 2);

    // Reset in the middle of a clock phase, stalled inside a packet.
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("lit_mid_tc_a", longint'(tc_a), 0);
    chk("lit_mid_st_a", longint'(st_a), 0);
    chk("lit_mid_inp_a", longint'(inp_a), 0);
    chk("lit_mid_ep_a", longint'(ep_a), 0);
    compare_all();
    step();
    set_in(0, 0, 32'h0, 4'h0, 4'h0, 0);
    resetn = 1'b1; step();
    chk("lit_fresh_ep_a", longint'(ep_a), 0);

    // tstrb set on a null byte.
    set_in(1, 1, 32'h5, 4'h3, 4'h1, 0); step();
    chk("lit_strb_ep_a", longint'(ep_a), 1);
    chk("lit_strb_bc_a", longint'(bc_a), 1);

    // tkeep=0 contributes no bytes; then tvalid dropped while stalled.
    do_reset();
    resetn = 1'b1; step();
    set_in(1, 1, 32'h6, 4'h0, 4'h0, 1); step();
    chk("lit_k0_bc_a", longint'(bc_a), 0);
    chk("lit_k0_tc_a", longint'(tc_a), 1);
    chk("lit_k0_ep_a", longint'(ep_a), 0);
    set_in(1, 0, 32'h7, 4'hF, 4'hF, 0); step();
    tvalid = 1'b0; step();
    chk("lit_drop_ep_a", longint'(ep_a), 1);

    // tvalid already high in the first cycle after release.
    do_reset();
    set_in(1, 1, 32'h8, 4'hF, 4'hF, 1);
    resetn = 1'b1; step();
    chk("lit_early_ep_a", longint'(ep_a), 1);
    chk("lit_early_tc_a", longint'(tc_a), 1);
    set_in(0, 0, 32'h0, 4'h0, 4'h0, 0); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_slave_monitor.md
Name: axi_stream_slave_monitor

Overview:
- Receiving-end companion to the AXI-Stream master-side property set.
- Sits passively on an AXI-Stream link at the slave (sink) side and observes every signal without driving any of them.
- Checks the master's handshake rules and flags them as sticky errors; these are assumptions in formal builds.
- Checks the slave's bounded-stall obligation, which is an assertion in formal builds.
- Exposes running transfer, byte and packet statistics.

Parameters:
- byte_width, 4, TDATA width in bytes.
- id_width, 0, TID width; 0 means absent, port kept 1 bit and ignored.
- dest_width, 0, TDEST width; 0 means absent, as above.
- user_width, 0, TUSER width; 0 means absent, as above.
- count_width, 32, width of every statistics counter.
- max_stall, 16, maximum consecutive tvalid&&!tready cycles allowed; 0 disables the stall check.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- resetn  in  1  reset; asynchronous assertion, active-low.
- tvalid  in  1  observed TVALID.
- tready  in  1  observed TREADY.
- tdata  in  8*byte_width  observed TDATA.
- tstrb  in  byte_width  observed TSTRB.
- tkeep  in  byte_width  observed TKEEP.
- tlast  in  1  observed TLAST.
- tid  in  max(id_width,1)  observed TID.
- tdest  in  max(dest_width,1)  observed TDEST.
- tuser  in  max(user_width,1)  observed TUSER.
- transfer_count  out  count_width  number of completed transfers.
- byte_count  out  count_width  number of data/position bytes transferred (tkeep bits set).
- packet_count  out  count_width  number of transfers with tlast.
- in_packet  out  1  a packet is open: a transfer without tlast has occurred since the last tlast transfer.
- stall_cycles  out  count_width  length of the current stall run, capped.
- err_protocol  out  1  sticky: master rule violated.
- err_stall  out  1  sticky: stall bound exceeded.

Behaviour:
- Reset: when resetn=0, all outputs and internal registers are cleared to 0 immediately (asynchronous). Release is synchronous to clk.
- xfer = tvalid && tready. All statistics are registered and visible the cycle after the transfer edge.
- transfer_count: +1 per xfer; saturates at all-ones.
- byte_count: + popcount(tkeep) per xfer, computed at count_width; saturates rather than wrapping. tkeep=0 adds 0.
- packet_count: +1 on xfer with tlast=1; saturates.
- in_packet: set on xfer with tlast=0; cleared on xfer with tlast=1. A single-beat packet leaves it 0.
- stall_cycles:
  - +1 each cycle with tvalid && !tready; cleared on xfer or !tvalid.
  - Capped at max_stall, or at all-ones when max_stall=0.
- err_stall:
  - Set on the edge where stall_cycles reaches max_stall, i.e. the max_stall-th consecutive stall cycle.
  - Never set when max_stall=0.
- err_protocol is set on the edge where any of these is seen:
  - (a) tvalid fell while the previous cycle had tvalid && !tready.
  - (b) previous cycle had tvalid && !tready, and tdata/tstrb/tkeep/tlast/enabled tid/tdest/tuser changed.
  - (c) tvalid=1 with (tstrb & ~tkeep) != 0.
  - (d) tvalid=1 in the first cycle after resetn release.
- Previous-cycle state: a registered copy of the payload plus a stalled flag. Both are invalid (checks a, b suppressed) during the first cycle after reset release.
- Both error flags stay set until resetn=0; multiple violations do not re-trigger or clear them.
- Reset mid-stall or mid-packet: counters, in_packet, stall state and errors are all discarded. The next cycle after release starts fresh.
- Formal builds:
  - Rules (a)-(d) are emitted as assumptions on the inputs.
  - The stall bound is an assertion.
  - A cover is emitted for a completed 2-beat packet.
  - In simulation only the flags are driven.

Decomposition:
- Shared package/header axi_stream_pkg: popcount function over byte_width, and the saturating-add helper.
- Sub-module axi_stream_sat_counter (params WIDTH, INC_WIDTH; ports clk, resetn, en, inc, count; async clear, saturating add), instantiated three times for transfer/byte/packet counts.
- Stall counter and checks remain inline.

Test Plan:
- Release reset, hold tready=1, send 3 beats tkeep=4'hF, the third with tlast -> transfer_count=3, byte_count=12, packet_count=1, in_packet=0, no errors.
- Send beat tkeep=4'h3 tlast=0, then beat tkeep=4'h1 tlast=1 -> byte_count=3; in_packet=1 after the first beat, 0 after the second; packet_count=1.
- max_stall=4, tvalid=1, tready=0 for 4 cycles -> err_stall=1 after the 4th edge, stall_cycles=4. Same with 3 stall cycles then tready=1 -> err_stall stays 0, stall_cycles returns to 0.
- Stall with tdata=32'hA5A5A5A5, then change tdata to 32'h0 while still stalled -> err_protocol=1 next cycle; it stays 1 through later clean traffic until resetn pulses low.
- tvalid=1 with tkeep=4'h1 and tstrb=4'h3 -> err_protocol=1. Separately, drop tvalid while stalled -> err_protocol=1.
- Assert resetn=0 mid-clock during a stalled, open packet with counters nonzero -> all outputs read 0 before the next clk edge. After release, tvalid=0 in the first cycle -> no error.
